dense_layer_seq: RTL and testbench

- Sequential fully-connected layer that sits directly upstream of the final classification layer.
- Produces the OUT_SIZE signed 32-bit logits that the classification stage arg-maxes.
- Uses one multiply-accumulate unit, time-multiplexed across all neurons.
- Reads weights and biases from an external synchronous ROM with one-cycle read latency; input activations are latched on start.

---
 rtl/dense_layer_seq.sv | 158 +++++++++++++++
 tb/tb_dense_layer_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: sequential fully-connected layer feeding the final
// classification stage. A single multiply-accumulate unit is shared across
// all neurons; weights and biases come from an external synchronous ROM with
// one cycle of read latency.
//
// State table:
//   IDLE  | waiting for start; outputs hold last results
//   ISSUE | one ROM read per cycle: IN_SIZE weights, then the bias
//   DRAIN | bias arrives; saturated result written, next neuron or DONE
//   DONE  | closing cycle; out_valid/busy update on leaving this state
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-low reset
//   start         new inference request, accepted in IDLE only
//   in_vector     IN_SIZE x IN_W signed activations, element i at [i*IN_W +: IN_W]
//   w_en, w_addr  ROM read request
//   w_data        ROM read data, valid one cycle after the request
//   busy          high from start acceptance until out_valid rises
//   output_vector OUT_SIZE x ACC_W signed results, element o at [o*ACC_W +: ACC_W]
//   out_valid     one-cycle pulse when all results are available
module dense_layer_seq #(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 3,
  parameter int IN_W     = 16,
  parameter int W_W      = 8,
  parameter int ACC_W    = 32,
  parameter int ADDR_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IN_SIZE*IN_W-1:0]   in_vector,
  output logic                      w_en,
  output logic [ADDR_W-1:0]         w_addr,
  input  logic [W_W-1:0]            w_data,
  output logic                      busy,
  output logic [OUT_SIZE*ACC_W-1:0] output_vector,
  output logic                      out_valid
);

  localparam int I_W   = $clog2(IN_SIZE + 1);
  localparam int O_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int P_W   = W_W + IN_W;
  localparam int SUM_W = ACC_W + W_W + $clog2(IN_SIZE + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]              state;
  logic [O_W-1:0]          o_idx;
  logic [I_W-1:0]          i_idx;
  logic [I_W-1:0]          rd_idx;
  logic                    rd_valid;
  logic [IN_SIZE*IN_W-1:0] in_lat;
  logic [SUM_W-1:0]        acc;

  logic                    issue_bias;
  logic [ADDR_W-1:0]       wt_addr;
  logic [ADDR_W-1:0]       bias_addr;
  logic [IN_W-1:0]         x_sel;
  logic [P_W-1:0]          prod;
  logic [SUM_W-1:0]        prod_ext;
  logic [SUM_W-1:0]        bias_ext;
  logic [SUM_W-1:0]        fin;
  logic [SUM_W-ACC_W:0]    fin_hi;
  logic [ACC_W-1:0]        sat_val;

  always_comb begin
    issue_bias = (i_idx == I_W'(IN_SIZE));
    wt_addr    = ADDR_W'(int'(o_idx) * IN_SIZE + int'(i_idx));
    bias_addr  = ADDR_W'(OUT_SIZE * IN_SIZE + int'(o_idx));
    w_en       = (state == ISSUE);
    w_addr     = '0;
    if (state == ISSUE)
      w_addr = issue_bias ? bias_addr : wt_addr;
  end

  // Operands are sign-extended to the product width first; the low P_W bits
  // of that unsigned product are the exact two's-complement signed product.
  always_comb begin
    x_sel    = in_lat[int'(rd_idx)*IN_W +: IN_W];
    prod     = {{IN_W{w_data[W_W-1]}}, w_data} * {{W_W{x_sel[IN_W-1]}}, x_sel};
    prod_ext = {{(SUM_W-P_W){prod[P_W-1]}}, prod};
    bias_ext = {{(SUM_W-W_W){w_data[W_W-1]}}, w_data};
    fin      = acc + bias_ext;
    fin_hi   = fin[SUM_W-1:ACC_W-1];
    // In range only when every bit above the ACC_W sign bit matches it.
    if (fin_hi == '0 || fin_hi == '1)
      sat_val = fin[ACC_W-1:0];
    else if (fin[SUM_W-1])
      sat_val = {1'b1, {(ACC_W-1){1'b0}}};
    else
      sat_val = {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      o_idx         <= '0;
      i_idx         <= '0;
      rd_idx        <= '0;
      rd_valid      <= 1'b0;
      in_lat        <= '0;
      acc           <= '0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      output_vector <= '0;
    end else begin
      out_valid <= 1'b0;
      rd_valid  <= 1'b0;
      if (rd_valid)
        acc <= acc + prod_ext;

      case (state)
        IDLE: begin
          // The out_valid cycle still belongs to the finishing run, so a
          // start seen there is not taken.
          if (start && !out_valid) begin
            in_lat <= in_vector;
            acc    <= '0;
            busy   <= 1'b1;
            o_idx  <= '0;
            i_idx  <= '0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          rd_valid <= !issue_bias;
          rd_idx   <= i_idx;
          if (issue_bias)
            state <= DRAIN;
          else
            i_idx <= i_idx + I_W'(1);
        end
        DRAIN: begin
          output_vector[int'(o_idx)*ACC_W +: ACC_W] <= sat_val;
          acc <= '0;
          if (o_idx == O_W'(OUT_SIZE - 1)) begin
            state <= DONE;
          end else begin
            o_idx <= o_idx + O_W'(1);
            i_idx <= '0;
            state <= ISSUE;
          end
        end
        default: begin
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Testbench for dense_layer_seq: a default instance (ACC_W=32) and a narrow
// instance (ACC_W=24) share stimulus, each with its own ROM image. Results are
// compared with a plain-arithmetic reference of the layer.
module tb_dense_layer_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] in_vector;

  logic         w_en_a, w_en_s;
  logic [7:0]   w_addr_a, w_addr_s;
  logic [7:0]   w_data_a, w_data_s;
  logic         busy_a, busy_s;
  logic [95:0]  ov_a;
  logic [71:0]  ov_s;
  logic         out_valid_a, out_valid_s;

  logic signed [7:0] rom_a [0:255];
  logic signed [7:0] rom_s [0:255];

  logic [95:0]  ov_a_cap;
  logic [71:0]  ov_s_cap;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (w_en_a) w_data_a <= rom_a[w_addr_a];
  always @(posedge clk) if (w_en_s) w_data_s <= rom_s[w_addr_s];

  dense_layer_seq dut_a (
    .clk(clk), .rst(rst), .start(start), .in_vector(in_vector),
    .w_en(w_en_a), .w_addr(w_addr_a), .w_data(w_data_a),
    .busy(busy_a), .output_vector(ov_a), .out_valid(out_valid_a)
  );

  dense_layer_seq #(.ACC_W(24)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_vector(in_vector),
    .w_en(w_en_s), .w_addr(w_addr_s), .w_data(w_data_s),
    .busy(busy_s), .output_vector(ov_s), .out_valid(out_valid_s)
  );

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: dot product plus bias in 64-bit arithmetic, then clamp.
  function automatic longint ref_out(input bit narrow, input int o, input logic [255:0] vec);
    longint s, lim;
    logic signed [7:0]  w;
    logic signed [15:0] x;
    s = 0;
    for (int i = 0; i < 16; i++) begin
      w = narrow ? rom_s[o*16+i] : rom_a[o*16+i];
      x = vec[i*16 +: 16];
      s += longint'(w) * longint'(x);
    end
    w = narrow ? rom_s[48+o] : rom_a[48+o];
    s += longint'(w);
    lim = longint'(1) << ((narrow ? 24 : 32) - 1);
    if (s > lim - 1) s = lim - 1;
    else if (s < -lim) s = -lim;
    return s;
  endfunction

  function automatic longint cap_a(input int o);
    logic signed [31:0] t;
    t = ov_a_cap[o*32 +: 32];
    return longint'(t);
  endfunction

  function automatic longint cap_s(input int o);
    logic signed [23:0] t;
    t = ov_s_cap[o*24 +: 24];
    return longint'(t);
  endfunction

  task automatic check_outputs(input string tag, input logic [255:0] vec);
    for (int o = 0; o < 3; o++) begin
      check_val($sformatf("%s_out_a%0d", tag, o), cap_a(o), ref_out(1'b0, o, vec));
      check_val($sformatf("%s_out_s%0d", tag, o), cap_s(o), ref_out(1'b1, o, vec));
    end
  endtask

  task automatic quiet_window(input string tag, input int n);
    int pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (out_valid_a || out_valid_s) pulses++;
    end
    check_val({tag, "_no_extra_valid"}, pulses, 0);
  endtask

  // One inference; rp1/rp2 are relative cycles at which start is re-pulsed.
  task automatic run_one(input string tag, input logic [255:0] vec,
                         input int rp1, input int rp2);
    int acc_e, rel, lat, busy_n, addr_err, exp_addr, k;
    logic [7:0] addr_q[$];
    bit seen, s_sync;
    @(negedge clk);
    in_vector = vec;
    start     = 1'b1;
    acc_e     = cyc + 1;
    seen = 1'b0; s_sync = 1'b0; lat = -1; busy_n = 0;
    for (int it = 0; it < 120 && !seen; it++) begin
      @(negedge clk);
      rel       = cyc - acc_e;
      in_vector = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
      start     = (rel == rp1 || rel == rp2);
      if (busy_a) busy_n++;
      if (w_en_a) addr_q.push_back(w_addr_a);
      if (out_valid_a) begin
        seen     = 1'b1;
        lat      = rel;
        s_sync   = out_valid_s;
        ov_a_cap = ov_a;
        ov_s_cap = ov_s;
      end
    end
    start = 1'b0;
    check_val({tag, "_latency"}, lat, 55);
    check_val({tag, "_busy_cycles"}, busy_n, 55);
    check_val({tag, "_valid_narrow"}, s_sync, 1);
    check_val({tag, "_addr_count"}, addr_q.size(), 51);
    addr_err = 0;
    k = 0;
    for (int o = 0; o < 3; o++)
      for (int i = 0; i <= 16; i++) begin
        exp_addr = (i < 16) ? o*16 + i : 48 + o;
        if (k >= addr_q.size() || int'(addr_q[k]) != exp_addr) addr_err++;
        k++;
      end
    check_val({tag, "_addr_seq_errs"}, addr_err, 0);
    check_outputs(tag, vec);
    quiet_window(tag, 60);
  endtask

  task automatic rand_roms();
    for (int k = 0; k < 256; k++) begin
      rom_a[k] = 8'($urandom);
      rom_s[k] = 8'($urandom);
    end
  endtask

  function automatic logic [255:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [255:0] vec;
    int acc_e, rel, first, second;

    rst = 1'b0; start = 1'b0; in_vector = '0;
    w_data_a = '0; w_data_s = '0;
    for (int k = 0; k < 256; k++) begin rom_a[k] = 8'sd0; rom_s[k] = 8'sd0; end
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_valid", out_valid_a, 0);
    check_val("rst_w_en", w_en_a, 0);
    check_val("rst_w_addr", w_addr_a, 0);
    check_val("rst_out_zero", (ov_a == '0 && ov_s == '0), 1);
    rst = 1'b1;

    // all weights 1, biases 0, inputs 1..16
    for (int k = 0; k < 48; k++) begin rom_a[k] = 8'sd1; rom_s[k] = 8'sd1; end
    for (int o = 0; o < 3; o++) begin rom_a[48+o] = 8'sd0; rom_s[48+o] = 8'sd0; end
    for (int i = 0; i < 16; i++) vec[i*16 +: 16] = 16'(i + 1);
    run_one("ones", vec, -1, -1);
    for (int o = 0; o < 3; o++) check_val($sformatf("ones_const%0d", o), cap_a(o), 136);

    // weights o-1, biases {5,-7,100}, inputs 1000
    for (int o = 0; o < 3; o++)
      for (int i = 0; i < 16; i++) begin
        rom_a[o*16+i] = 8'(o - 1);
        rom_s[o*16+i] = 8'(o - 1);
      end
    rom_a[48] = 8'sd5; rom_a[49] = -8'sd7; rom_a[50] = 8'sd100;
    rom_s[48] = 8'sd5; rom_s[49] = -8'sd7; rom_s[50] = 8'sd100;
    for (int i = 0; i < 16; i++) vec[i*16 +: 16] = 16'd1000;
    run_one("signed", vec, -1, -1);
    check_val("signed_const0", cap_a(0), -15995);
    check_val("signed_const1", cap_a(1), -7);
    check_val("signed_const2", cap_a(2), 16100);

    // saturation on the 24-bit instance
    rand_roms();
    for (int k = 0; k < 51; k++) rom_s[k] = 8'sd127;
    for (int i = 0; i < 16; i++) vec[i*16 +: 16] = 16'd32767;
    run_one("sat_pos", vec, -1, -1);
    for (int o = 0; o < 3; o++) check_val($sformatf("sat_pos_const%0d", o), cap_s(o), 8388607);
    for (int k = 0; k < 51; k++) rom_s[k] = -8'sd128;
    run_one("sat_neg", vec, -1, -1);
    for (int o = 0; o < 3; o++) check_val($sformatf("sat_neg_const%0d", o), cap_s(o), -8388608);

    // start re-pulsed mid-run and in the DONE cycle
    rand_roms();
    run_one("repulse", rand_vec(), 10, 54);

    // reset in the middle of a run
    vec = rand_vec();
    @(negedge clk);
    in_vector = vec; start = 1'b1; acc_e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int it = 0; it < 40 && (cyc - acc_e) < 19; it++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_busy", busy_a, 0);
    check_val("midrst_w_en", w_en_a, 0);
    check_val("midrst_valid", out_valid_a, 0);
    check_val("midrst_out_zero", (ov_a == '0 && ov_s == '0), 1);
    rst = 1'b1;
    quiet_window("midrst", 70);
    run_one("after_rst", rand_vec(), -1, -1);

    // start held high: back-to-back runs
    rand_roms();
    vec = rand_vec();
    @(negedge clk);
    in_vector = vec; start = 1'b1; acc_e = cyc + 1;
    first = -1; second = -1;
    for (int it = 0; it < 200 && second < 0; it++) begin
      @(negedge clk);
      rel = cyc - acc_e;
      if (out_valid_a) begin
        if (first < 0) first = rel;
        else begin
          second = rel;
          ov_a_cap = ov_a;
          ov_s_cap = ov_s;
        end
      end
    end
    start = 1'b0;
    check_val("b2b_first", first, 55);
    check_val("b2b_gap", second - first, 57);
    check_outputs("b2b", vec);
    quiet_window("b2b", 70);

    for (int r = 0; r < 3; r++) begin
      rand_roms();
      run_one($sformatf("rand%0d", r), rand_vec(), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
